// File: rtl/change_payout.sv
// Coin hopper payout sequencer: one eject pulse per coin, waits for the hopper ack, faults on timeout.
// Build option: define PAYOUT_COIN2_EN to pay with 2-unit coins greedily (otherwise eject_2 stays 0).
//
//   state    | meaning
//   IDLE     | waiting for a change request edge
//   EJECT    | eject pulse for the chosen coin is high
//   WAIT_ACK | pulse finished, waiting for the hopper coin-passed edge
//   GAP      | quiet time between coins
//   DONE     | one-cycle completion pulse
//   FAULT    | hopper ack timed out; held until fault_clr
module change_payout #(
    parameter int AMT_W        = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             hopper_ack,
    input  logic             fault_clr,
    output logic             eject_1,
    output logic             eject_2,
    output logic             busy,
    output logic [AMT_W-1:0] remaining,
    output logic             done,
    output logic             fault
);

`ifdef PAYOUT_COIN2_EN
    localparam bit COIN2_EN = 1'b1;
`else
    localparam bit COIN2_EN = 1'b0;
`endif

    localparam int CNT_MAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EJECT,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state;
    logic             req_q;
    logic             ack_q;
    logic             coin2;
    logic [CNT_W-1:0] cnt;
    logic             req_edge;
    logic             ack_edge;
    logic [AMT_W-1:0] rem_after_ack;

    // A 2-unit coin is only picked with at least 2 owed, so the subtraction below cannot wrap.
    function automatic logic use_coin2(input logic [AMT_W-1:0] owed);
        return COIN2_EN && (owed >= AMT_W'(2));
    endfunction

    always_comb begin
        req_edge      = req & ~req_q;
        ack_edge      = hopper_ack & ~ack_q;
        rem_after_ack = remaining - (coin2 ? AMT_W'(2) : AMT_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            coin2     <= 1'b0;
            cnt       <= '0;
            eject_1   <= 1'b0;
            eject_2   <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            req_q <= req;
            ack_q <= hopper_ack;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_edge) begin
                        if (amount != '0) begin
                            remaining <= amount;
                            busy      <= 1'b1;
                            coin2     <= use_coin2(amount);
                            eject_2   <= use_coin2(amount);
                            eject_1   <= ~use_coin2(amount);
                            cnt       <= PULSE_LOAD;
                            state     <= S_EJECT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                // An ack that arrives while the pulse is still high is taken immediately.
                S_EJECT, S_WAIT_ACK: begin
                    if (ack_edge) begin
                        eject_1   <= 1'b0;
                        eject_2   <= 1'b0;
                        remaining <= rem_after_ack;
                        if (rem_after_ack == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cnt   <= PULSE_LOAD;
                            state <= S_GAP;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (state == S_EJECT) begin
                        eject_1 <= 1'b0;
                        eject_2 <= 1'b0;
                        cnt     <= TIMEOUT_LOAD;
                        state   <= S_WAIT_ACK;
                    end else begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end
                end

                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        coin2   <= use_coin2(remaining);
                        eject_2 <= use_coin2(remaining);
                        eject_1 <= ~use_coin2(remaining);
                        cnt     <= PULSE_LOAD;
                        state   <= S_EJECT;
                    end
                end

                S_DONE: begin
                    busy      <= 1'b0;
                    remaining <= '0;
                    state     <= S_IDLE;
                end

                S_FAULT: begin
                    if (fault_clr) begin
                        fault     <= 1'b0;
                        busy      <= 1'b0;
                        remaining <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_payout.sv
// Bench for change_payout: table of payout scenarios, random payouts against a coin-count model,
// and hand-written sequences for reset abort, early ack and idle noise.
module tb_change_payout;

    localparam int AMT_W = 4;
    localparam int PULSE = 4;
    localparam int TMO   = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic [AMT_W-1:0] amount;
    logic             hopper_ack;
    logic             fault_clr;
    logic             eject_1;
    logic             eject_2;
    logic             busy;
    logic [AMT_W-1:0] remaining;
    logic             done;
    logic             fault;

    change_payout #(.AMT_W(AMT_W), .PULSE_CYCLES(PULSE), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (req),
        .amount     (amount),
        .hopper_ack (hopper_ack),
        .fault_clr  (fault_clr),
        .eject_1    (eject_1),
        .eject_2    (eject_2),
        .busy       (busy),
        .remaining  (remaining),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Reference: how many coins of each kind a full payout of 'a' units takes.
    function automatic void model(input int a, output int n1, output int n2);
`ifdef PAYOUT_COIN2_EN
        n2 = a / 2;
        n1 = a % 2;
`else
        n2 = 0;
        n1 = a;
`endif
    endfunction

    typedef struct {
        int amt;
        int dly;
        int hold;
        int dbl;
        int n1;
        int n2;
        int flt;
        int rem_f;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    // Drives one request and plays the hopper: ack 'dly' cycles after each pulse falls.
    task automatic run_case(input int amt, input int dly, input int hold, input int dbl,
                            output int n1, output int n2, output int faulted, output int dones);
        int m1, m2, exp_rem, idx, run, low_run, ack_cnt;
        int both, bad_w, bad_rem, bad_gap, bad_busy, bad_order, bad_done;
        bit prev_e, prev_done, cur2, e, finished, want2;
        model(amt, m1, m2);
        n1 = 0; n2 = 0; faulted = 0; dones = 0;
        exp_rem = amt; idx = 0; run = 0; low_run = 0; ack_cnt = 0;
        both = 0; bad_w = 0; bad_rem = 0; bad_gap = 0; bad_busy = 0; bad_order = 0; bad_done = 0;
        prev_e = 0; prev_done = 0; cur2 = 0; finished = 0;
        @(negedge clk);
        amount = AMT_W'(amt);
        req = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            e = eject_1 | eject_2;
            if (eject_1 && eject_2) both++;
            if (e && !busy) bad_busy++;
            if (amt == 0 && busy) bad_busy++;
            if (e && !prev_e) begin
                want2 = (idx < m2);
                if (eject_2 != want2) bad_order++;
                if (int'(remaining) != exp_rem) bad_rem++;
                if (idx > 0 && low_run != dly + PULSE) bad_gap++;
                cur2 = eject_2;
                run = 0;
            end
            if (e) run++;
            else low_run++;
            if (!e && prev_e) begin
                if (run != PULSE) bad_w++;
                if (cur2) begin n2++; exp_rem -= 2; end
                else begin n1++; exp_rem -= 1; end
                idx++;
                ack_cnt = dly;
                low_run = 1;
            end
            if (prev_done) begin
                if (busy || done || remaining != '0) bad_done++;
                finished = 1;
            end
            if (done) dones++;
            if (fault) begin
                faulted = 1;
                finished = 1;
                check("fault_latency", low_run - 1, TMO);
                break;
            end
            prev_e = e;
            prev_done = done;
            hopper_ack = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) hopper_ack = 1'b1;
            end
            req = (hold != 0) || (dbl != 0 && cyc >= 4 && cyc < 6);
        end
        hopper_ack = 1'b0;
        req = 1'b0;
        check("terminated", int'(finished), 1);
        check("eject_exclusive", both, 0);
        check("pulse_width", bad_w, 0);
        check("coin_order", bad_order, 0);
        check("remaining_seq", bad_rem, 0);
        check("gap_len", bad_gap, 0);
        check("busy_track", bad_busy, 0);
        check("done_shape", bad_done, 0);
    endtask

    initial begin
        int n1, n2, flt, dn, m1, m2, a, d, bad, seen;

`ifdef PAYOUT_COIN2_EN
        vecs[0] = '{3,   2,   0, 0, 1,  1, 0, 0};
        vecs[1] = '{0,   2,   0, 0, 0,  0, 0, 0};
        vecs[2] = '{15,  1,   0, 0, 1,  7, 0, 0};
        vecs[3] = '{3,   300, 0, 0, 0,  1, 1, 3};
        vecs[4] = '{5,   3,   1, 0, 1,  2, 0, 0};
        vecs[5] = '{4,   2,   0, 1, 0,  2, 0, 0};
        vecs[6] = '{2,   255, 0, 0, 0,  1, 0, 0};
        vecs[7] = '{2,   256, 0, 0, 0,  1, 1, 2};
        vecs[8] = '{1,   1,   0, 0, 1,  0, 0, 0};
`else
        vecs[0] = '{3,   2,   0, 0, 3,  0, 0, 0};
        vecs[1] = '{0,   2,   0, 0, 0,  0, 0, 0};
        vecs[2] = '{15,  1,   0, 0, 15, 0, 0, 0};
        vecs[3] = '{3,   300, 0, 0, 1,  0, 1, 3};
        vecs[4] = '{5,   3,   1, 0, 5,  0, 0, 0};
        vecs[5] = '{4,   2,   0, 1, 4,  0, 0, 0};
        vecs[6] = '{2,   255, 0, 0, 2,  0, 0, 0};
        vecs[7] = '{2,   256, 0, 0, 1,  0, 1, 2};
        vecs[8] = '{1,   1,   0, 0, 1,  0, 0, 0};
`endif

        rst_n = 1'b0; req = 1'b0; amount = '0; hopper_ack = 1'b0; fault_clr = 1'b0;
        #12;
        check("rst_eject", int'(eject_1 | eject_2), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_fault", int'(done | fault), 0);
        check("rst_remaining", int'(remaining), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stray ack edge in IDLE must not move anything.
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || eject_1 || eject_2 || remaining != '0) bad++;
        end
        check("idle_spurious_ack", bad, 0);

        for (int i = 0; i < NV; i++) begin
            run_case(vecs[i].amt, vecs[i].dly, vecs[i].hold, vecs[i].dbl, n1, n2, flt, dn);
            check($sformatf("v%0d_n1", i), n1, vecs[i].n1);
            check($sformatf("v%0d_n2", i), n2, vecs[i].n2);
            check($sformatf("v%0d_fault", i), flt, vecs[i].flt);
            check($sformatf("v%0d_dones", i), dn, (vecs[i].flt != 0) ? 0 : 1);
            if (vecs[i].flt != 0) begin
                req = 1'b1;
                repeat (3) @(negedge clk);
                req = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d_fault_held", i), int'(fault), 1);
                check($sformatf("v%0d_fault_busy", i), int'(busy), 1);
                check($sformatf("v%0d_fault_rem", i), int'(remaining), vecs[i].rem_f);
                check($sformatf("v%0d_fault_eject", i), int'(eject_1 | eject_2), 0);
                fault_clr = 1'b1;
                @(negedge clk);
                fault_clr = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d_clr", i), int'({fault, busy}), 0);
                check($sformatf("v%0d_clr_rem", i), int'(remaining), 0);
            end
            repeat (2) @(negedge clk);
        end

        // Ack while the pulse is still high cuts it short and completes the coin.
        @(negedge clk);
        amount = AMT_W'(1);
        req = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (eject_1 | eject_2) seen = 1;
        end
        check("early_ack_pulse_seen", seen, 1);
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        check("early_ack_eject_off", int'(eject_1 | eject_2), 0);
        check("early_ack_done", int'(done), 1);
        check("early_ack_rem", int'(remaining), 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a pulse drops everything without a clock edge.
        @(negedge clk);
        amount = AMT_W'(3);
        req = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (eject_1 | eject_2) seen = 1;
        end
        check("rst_mid_pulse_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_eject", int'(eject_1 | eject_2), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rem", int'(remaining), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(1, 1, 0, 0, n1, n2, flt, dn);
        check("after_rst_n1", n1, 1);
        check("after_rst_done", dn, 1);

        for (int r = 0; r < 20; r++) begin
            a = int'($urandom_range(0, 15));
            d = int'($urandom_range(1, 5));
            model(a, m1, m2);
            run_case(a, d, 0, 0, n1, n2, flt, dn);
            check($sformatf("rnd%0d_a%0d_n1", r, a), n1, m1);
            check($sformatf("rnd%0d_a%0d_n2", r, a), n2, m2);
            check($sformatf("rnd%0d_fault", r), flt, 0);
            check($sformatf("rnd%0d_dones", r), dn, 1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/change_payout.md
Name: change_payout

Overview:
Downstream stage of the vending controller. Consumes the change-request strobe and change amount that the controller produces, and drives the coin hopper.
- Issues one eject pulse per coin and waits for the hopper's coin-passed acknowledge.
- Decrements the remaining amount per acknowledged coin.
- Reports completion, or a stuck-hopper fault on acknowledge timeout.

Parameters:
AMT_W, 4, width of amount and remaining (matches the controller's 4-bit change_display)
PULSE_CYCLES, 4, eject pulse width and inter-coin gap, in clk cycles (>=1)
ACK_TIMEOUT, 255, clk cycles to wait for hopper_ack after the pulse ends before faulting (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low; 0 forces all state and outputs to reset values immediately
req  input  1  change request from the controller (its change_dispensed); only the 0->1 edge is used
amount  input  AMT_W  change value in coin units (the controller's change_display); latched on the accepted req edge
hopper_ack  input  1  hopper coin-passed sensor; only the 0->1 edge is used
fault_clr  input  1  clears FAULT; ignored in all other states
eject_1  output  1  eject one 1-unit coin while high
eject_2  output  1  eject one 2-unit coin while high
busy  output  1  payout in progress, or faulted
remaining  output  AMT_W  units still owed
done  output  1  one-cycle pulse when payout completes
fault  output  1  sticky hopper-timeout flag

Behaviour:
- Reset (reset=0): state=IDLE; eject_1, eject_2, busy, done and fault are 0; remaining=0; edge-detect flops=0.
- All outputs are registered. eject_1 and eject_2 are never high together.
- req edge = sampled req is 1 and the previous sample was 0. Same rule for hopper_ack.
- States: IDLE, EJECT, WAIT_ACK, GAP, DONE, FAULT.
- IDLE:
  - req edge with amount!=0 -> remaining<=amount, busy<=1, -> EJECT.
  - req edge with amount==0 -> DONE; no eject is issued.
  - hopper_ack edges are ignored.
- Coin choice, made on entry to EJECT: 2-unit coin if the optional feature is enabled and remaining>=2; otherwise 1-unit coin. The choice is held until the coin is acknowledged.
- EJECT:
  - The chosen eject output is high for exactly PULSE_CYCLES cycles, starting the cycle after entry. Then -> WAIT_ACK with the timeout counter at 0.
  - An ack edge during EJECT is accepted: the pulse is cut short and the ack is handled as in WAIT_ACK.
- WAIT_ACK:
  - ack edge -> remaining <= remaining minus the coin value. If the result is 0 -> DONE, else -> GAP.
  - No ack within ACK_TIMEOUT cycles -> FAULT.
- GAP: all ejects low for PULSE_CYCLES cycles, then -> EJECT.
- DONE: done=1 for exactly one cycle, busy<=0, remaining=0, -> IDLE. A new req is accepted from the next cycle.
- FAULT:
  - fault=1, busy=1, ejects low, remaining frozen (shows the undelivered amount).
  - fault_clr=1 -> fault<=0, busy<=0, remaining<=0, -> IDLE.
- req edges are ignored while busy=1, including in FAULT. They are not queued.
- Arithmetic: subtraction never underflows, because a 2-unit coin is chosen only when remaining>=2.
- Reset asserted mid-payout aborts immediately. The eject output drops asynchronously; no partial-count recovery.

Optional Feature:
Macro PAYOUT_COIN2_EN.
- Defined: 2-unit coins are used greedily, with 1-unit coins only for an odd remainder.
- Undefined: eject_2 is tied to 0, and every coin is 1-unit.

Test Plan:
- Assert reset=0 during an eject_1 pulse with remaining=2 -> eject_1, busy and remaining go to 0 without waiting for a clock edge; state=IDLE after release.
- PAYOUT_COIN2_EN defined: amount=3, req pulse, ack 2 cycles after each pulse -> one eject_2 pulse of 4 cycles, remaining 3->1, then one eject_1 pulse, remaining 1->0, then a single done pulse and busy=0. Same run with the macro undefined -> three eject_1 pulses, remaining 3->2->1->0.
- amount=0, req pulse -> done high for exactly 1 cycle; eject_1 and eject_2 stay 0; busy stays 0.
- amount=3, hopper_ack held 0 -> after 4 pulse cycles + 255 cycles, fault=1, busy=1, remaining=3 (or 1 if the first coin was acked). Then fault_clr=1 -> fault=0, busy=0, remaining=0.
- Spurious hopper_ack in IDLE -> no change. A second req edge and req held high during payout -> exactly one payout occurs.
- PAYOUT_COIN2_EN defined: amount=15 -> seven eject_2 pulses, then one eject_1 pulse, each separated by a 4-cycle gap; remaining 15,13,...,1,0; then done.
